// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types for the I/D memory arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2,
    ARB_RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_t;

  // Round-robin pick; only meaningful when at least one request is present.
  function automatic arb_owner_t pick_owner(input logic i_req, input logic d_req,
                                            input arb_owner_t last_owner);
    return (i_req && (!d_req || last_owner == OWNER_D)) ? OWNER_I : OWNER_D;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between fetch (I) and load/store (D)
// Registered round-robin grant, latched response and a per-transaction ack watchdog.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic                i_err,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ack,
  output logic                d_err,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                stall
);

  localparam int BE_W  = DATA_W / 8;
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WDOG_EN = (TIMEOUT > 0);
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

  arb_state_t          state;
  arb_owner_t          last_owner;
  logic [ADDR_W-1:0]   cap_addr;
  logic                cap_we;
  logic [DATA_W-1:0]   cap_wdata;
  logic [BE_W-1:0]     cap_be;
  logic [TMR_W-1:0]    timer;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;

  // The memory side only ever sees captured values, so requesters may change freely after grant.
  assign mem_req   = (state == ARB_GRANT_I) || (state == ARB_GRANT_D);
  assign mem_we    = mem_req && cap_we;
  assign mem_addr  = cap_addr;
  assign mem_wdata = cap_wdata;
  assign mem_be    = cap_be;

  assign i_rdata = rsp_rdata;
  assign i_err   = rsp_err;
  assign d_rdata = rsp_rdata;
  assign d_err   = rsp_err;

  assign stall = mem_req || ((state == ARB_IDLE) && (i_req || d_req));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      last_owner <= OWNER_D;
      cap_addr   <= '0;
      cap_we     <= 1'b0;
      cap_wdata  <= '0;
      cap_be     <= '0;
      timer      <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        ARB_IDLE: begin
          timer <= '0;
          if (i_req || d_req) begin
            if (pick_owner(i_req, d_req, last_owner) == OWNER_I) begin
              cap_addr   <= i_addr;
              cap_we     <= 1'b0;
              cap_wdata  <= '0;
              cap_be     <= '1;
              last_owner <= OWNER_I;
              state      <= ARB_GRANT_I;
            end else begin
              cap_addr   <= d_addr;
              cap_we     <= d_we;
              cap_wdata  <= d_wdata;
              cap_be     <= d_be;
              last_owner <= OWNER_D;
              state      <= ARB_GRANT_D;
            end
          end
        end
        ARB_GRANT_I, ARB_GRANT_D: begin
          // An ack arriving on the expiry cycle still counts as success.
          if (mem_ack) begin
            rsp_rdata <= cap_we ? '0 : mem_rdata;
            rsp_err   <= 1'b0;
            i_ack     <= (state == ARB_GRANT_I);
            d_ack     <= (state == ARB_GRANT_D);
            state     <= ARB_RESP;
          end else if (WDOG_EN && (timer == TMR_LAST)) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            i_ack     <= (state == ARB_GRANT_I);
            d_ack     <= (state == ARB_GRANT_D);
            state     <= ARB_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ARB_RESP: begin
          timer <= '0;
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
